// File: rtl/bidirection_rotation.sv
// Registered bidirectional barrel rotator: a log2(WIDTH)-stage left-rotate network
// fed with a negated amount for right rotates, followed by a single output register.
module bidirection_rotation #(
  parameter  int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             lr,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] data_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] data_out
);

  logic [AMT_W-1:0] eff_amt;
  logic [WIDTH-1:0] stage [AMT_W+1];

  // Right by k is left by (WIDTH - k) mod WIDTH, i.e. the two's complement of k.
  assign eff_amt  = lr ? amount : (~amount + AMT_W'(1));
  assign stage[0] = data_in;

  for (genvar j = 0; j < AMT_W; j++) begin : g_stage
    localparam int S = 1 << j;
    assign stage[j+1] = eff_amt[j]
                      ? {stage[j][WIDTH-1-S:0], stage[j][WIDTH-1:WIDTH-S]}
                      : stage[j];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) data_out <= stage[AMT_W];
    end
  end

endmodule

// File: tb/tb_bidirection_rotation.sv
// Directed and table-driven bench for bidirection_rotation (WIDTH = 8).
module tb_bidirection_rotation;

  typedef struct {
    logic       lr;
    logic [2:0] amt;
    logic [7:0] din;
    logic [7:0] exp_dout;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       lr;
  logic [2:0] amount;
  logic [7:0] data_in;
  logic       out_valid;
  logic [7:0] data_out;

  int checks = 0;
  int errors = 0;

  vec_t tbl[$];

  bidirection_rotation #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .lr       (lr),
    .amount   (amount),
    .data_in  (data_in),
    .out_valid(out_valid),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model(input logic l, input int k, input logic [7:0] d);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (l) r[i] = d[(i - k + 8) % 8];
      else   r[i] = d[(i + k) % 8];
    end
    return r;
  endfunction

  function automatic vec_t mk(input logic l, input logic [2:0] a, input logic [7:0] d,
                              input logic [7:0] e);
    vec_t v;
    v.lr = l; v.amt = a; v.din = d; v.exp_dout = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive inputs before the edge, sample 1 time unit after it.
  task automatic step(input logic v, input logic l, input logic [2:0] a, input logic [7:0] d);
    in_valid = v; lr = l; amount = a; data_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] r_res;
    logic [2:0] k;
    logic [2:0] kl;

    tbl.push_back(mk(1'b1, 3'd0, 8'b10010010, 8'b10010010));
    tbl.push_back(mk(1'b1, 3'd1, 8'b10010010, 8'b00100101));
    tbl.push_back(mk(1'b1, 3'd2, 8'b10010010, 8'b01001010));
    tbl.push_back(mk(1'b1, 3'd3, 8'b10010010, 8'b10010100));
    tbl.push_back(mk(1'b1, 3'd4, 8'b10010010, 8'b00101001));
    tbl.push_back(mk(1'b1, 3'd5, 8'b10010010, 8'b01010010));
    tbl.push_back(mk(1'b1, 3'd6, 8'b10010010, 8'b10100100));
    tbl.push_back(mk(1'b1, 3'd7, 8'b10010010, 8'b01001001));
    tbl.push_back(mk(1'b0, 3'd0, 8'b10010010, 8'b10010010));
    tbl.push_back(mk(1'b0, 3'd1, 8'b10010010, 8'b01001001));
    tbl.push_back(mk(1'b0, 3'd2, 8'b10010010, 8'b10100100));
    tbl.push_back(mk(1'b0, 3'd3, 8'b10010010, 8'b01010010));
    tbl.push_back(mk(1'b0, 3'd4, 8'b10010010, 8'b00101001));
    tbl.push_back(mk(1'b0, 3'd5, 8'b10010010, 8'b10010100));
    tbl.push_back(mk(1'b0, 3'd6, 8'b10010010, 8'b01001010));
    tbl.push_back(mk(1'b0, 3'd7, 8'b10010010, 8'b00100101));
    tbl.push_back(mk(1'b0, 3'd1, 8'h01, 8'h80));
    tbl.push_back(mk(1'b1, 3'd1, 8'h80, 8'h01));
    tbl.push_back(mk(1'b1, 3'd3, 8'hC3, 8'h1E));
    tbl.push_back(mk(1'b0, 3'd3, 8'hC3, 8'h78));

    reset = 1'b1; in_valid = 1'b1; lr = 1'b1; amount = 3'd3; data_in = 8'hFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_dout", data_out, 8'h00);
    check("reset_valid", {7'd0, out_valid}, 8'd1 - 8'd1);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      step(1'b1, tbl[i].lr, tbl[i].amt, tbl[i].din);
      check($sformatf("table[%0d]", i), data_out, tbl[i].exp_dout);
      check($sformatf("table_valid[%0d]", i), {7'd0, out_valid}, 8'd1);
    end

    // All-zero and all-one words are invariant under every rotate.
    for (int p = 0; p < 2; p++) begin
      d = (p == 0) ? 8'h00 : 8'hFF;
      for (int dir = 0; dir < 2; dir++)
        for (int a = 0; a < 8; a++) begin
          step(1'b1, dir[0], a[2:0], d);
          check($sformatf("corner_%h_lr%0d_k%0d", d, dir, a), data_out, d);
        end
    end

    // Right by k must match left by (8-k) mod 8, and both must match the model.
    for (int n = 0; n < 1000; n++) begin
      d  = 8'($urandom);
      k  = 3'($urandom_range(0, 7));
      kl = 3'(8 - int'(k));
      step(1'b1, 1'b0, k, d);
      r_res = data_out;
      check($sformatf("rand_right_k%0d_%h", k, d), r_res, model(1'b0, int'(k), d));
      step(1'b1, 1'b1, kl, d);
      check($sformatf("rand_left_k%0d_%h", kl, d), data_out, model(1'b1, int'(kl), d));
      check($sformatf("rand_equiv_k%0d_%h", k, d), data_out, r_res);
    end

    // Hold: result stays, out_valid drops while in_valid is low.
    step(1'b1, 1'b1, 3'd0, 8'hA5);
    check("hold_load", data_out, 8'hA5);
    for (int c = 0; c < 3; c++) begin
      step(1'b0, c[0], 3'(c + 1), 8'(8'h11 * (c + 2)));
      check($sformatf("hold_dout[%0d]", c), data_out, 8'hA5);
      check($sformatf("hold_valid[%0d]", c), {7'd0, out_valid}, 8'd0);
    end

    // Reset mid-stream, then first valid input after reset.
    step(1'b1, 1'b1, 3'd2, 8'h0F);
    check("stream_pre_reset", data_out, 8'h3C);
    reset = 1'b1;
    step(1'b1, 1'b0, 3'd5, 8'h5A);
    check("midreset_dout", data_out, 8'h00);
    check("midreset_valid", {7'd0, out_valid}, 8'd0);
    reset = 1'b0;
    step(1'b1, 1'b1, 3'd7, 8'h01);
    check("post_reset_dout", data_out, 8'h80);
    check("post_reset_valid", {7'd0, out_valid}, 8'd1);
    step(1'b0, 1'b0, 3'd0, 8'h00);
    check("post_reset_idle_valid", {7'd0, out_valid}, 8'd0);
    check("post_reset_idle_dout", data_out, 8'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
